// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package pipelined_cla_addsub_pkg;

  // Default datapath width and bits resolved per pipeline stage.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Width of one carry-lookahead group.
  localparam int GRP = 4;

  // Operation encoding on the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result bus of the adder/subtractor.
//
// Handshake: an operand set transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A producer keeps
// its payload stable while its valid is high and not yet accepted. in_ready is the
// only signal that depends combinationally on the other side (on out_ready).
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub_cla_group4.sv
// 4-bit carry-lookahead group: sum, carry-out and group propagate/generate.
module cla_group4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // p uses a|b: sufficient for carries; the sum still uses a^b.
  assign g = a_i & b_i;
  assign p = a_i | b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

  assign g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o    = &p;
  assign cout_o = g_o | (p_o & cin_i);

  assign s_o = a_i ^ b_i ^ c;
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor. Each stage resolves SEG bits
// with a chain of 4-bit lookahead groups; the segment carry is registered into the next
// stage together with the skewed operands and the deskewed partial sum.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_addsub_if.slave bus
);
  localparam int NSTAGES = WIDTH / SEG;
  localparam int NGRP    = SEG / GRP;

  // Rank 0 holds the accepted operands; rank k+1 holds the result of segment k.
  logic [NSTAGES:0]   vld_q;
  logic [NSTAGES:0]   cy_q;
  logic [NSTAGES:0]   sub_q;
  logic [NSTAGES:0]   amsb_q;
  logic [NSTAGES:0]   bmsb_q;
  logic [WIDTH-1:0]   sum_q [0:NSTAGES];
  logic [WIDTH-1:0]   opa_q [0:NSTAGES-1];
  logic [WIDTH-1:0]   opb_q [0:NSTAGES-1];

  logic                          advance;
  logic [WIDTH-1:0]              b_eff;
  logic                          c0;
  logic [NSTAGES-1:0][SEG-1:0]   seg_s;
  logic [NSTAGES-1:0]            seg_co;

  // A full output register that is not being drained freezes the whole pipe.
  assign advance      = !vld_q[NSTAGES] || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction is a + ~b + 1, with ci acting as an inverted borrow-in.
  assign b_eff = (bus.sub == OP_ADD) ? bus.b : ~bus.b;
  assign c0    = bus.ci ^ (bus.sub == OP_SUB);

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [NGRP:0]   gc;
    logic [NGRP-1:0] gp;
    logic [NGRP-1:0] gg;
    logic            sg;
    logic            sp;
    logic            ripple_co_unused;

    assign gc[0] = cy_q[k];

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      cla_group4 u_grp (
        .a_i   (opa_q[k][k*SEG + j*GRP +: GRP]),
        .b_i   (opb_q[k][k*SEG + j*GRP +: GRP]),
        .cin_i (gc[j]),
        .s_o   (seg_s[k][j*GRP +: GRP]),
        .cout_o(gc[j+1]),
        .p_o   (gp[j]),
        .g_o   (gg[j])
      );
    end

    // Segment-level generate/propagate from the group P/G terms.
    always_comb begin
      sg = 1'b0;
      sp = 1'b1;
      for (int j = 0; j < NGRP; j++) begin
        sg = gg[j] | (gp[j] & sg);
        sp = sp & gp[j];
      end
    end

    // The registered carry comes from the lookahead terms; the last group's ripple
    // carry-out carries the same value and is not needed.
    assign seg_co[k]        = sg | (sp & cy_q[k]);
    assign ripple_co_unused = gc[NGRP];
  end

  // Pipeline ranks: load on advance, hold on stall, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      sub_q  <= '0;
      amsb_q <= '0;
      bmsb_q <= '0;
      for (int k = 0; k <= NSTAGES; k++) sum_q[k] <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0]  <= bus.in_valid;
      opa_q[0]  <= bus.a;
      opb_q[0]  <= b_eff;
      cy_q[0]   <= c0;
      sub_q[0]  <= bus.sub;
      amsb_q[0] <= bus.a[WIDTH-1];
      bmsb_q[0] <= bus.b[WIDTH-1];
      sum_q[0]  <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        vld_q[k+1]                <= vld_q[k];
        cy_q[k+1]                 <= seg_co[k];
        sub_q[k+1]                <= sub_q[k];
        amsb_q[k+1]               <= amsb_q[k];
        bmsb_q[k+1]               <= bmsb_q[k];
        sum_q[k+1]                <= sum_q[k];
        sum_q[k+1][k*SEG +: SEG]  <= seg_s[k];
      end
      for (int k = 0; k < NSTAGES - 1; k++) begin
        opa_q[k+1] <= opa_q[k];
        opb_q[k+1] <= opb_q[k];
      end
    end
  end

  // Flags from the final rank only.
  logic beff_msb;
  assign beff_msb      = bmsb_q[NSTAGES] ^ (sub_q[NSTAGES] == OP_SUB);
  assign bus.out_valid = vld_q[NSTAGES];
  assign bus.s         = sum_q[NSTAGES];
  assign bus.co        = cy_q[NSTAGES];
  assign bus.ovf       = (amsb_q[NSTAGES] == beff_msb) && (sum_q[NSTAGES][WIDTH-1] != amsb_q[NSTAGES]);
  assign bus.zero      = ~|sum_q[NSTAGES];
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed and random checks of pipelined_cla_addsub at WIDTH=32, SEG=8.
module tb_pipelined_cla_addsub;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0;
  int   last_hand = 0;
  int   acc_cyc = 0;

  logic [W+2:0] exp_q[$];

  pipelined_cla_addsub_if #(.WIDTH(W)) bus ();

  pipelined_cla_addsub #(.WIDTH(W), .SEG(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] pk(input logic co, input logic ovf, input logic zero,
                                      input logic [W-1:0] s);
    return {co, ovf, zero, s};
  endfunction

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         ov;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci ^ sub};
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {t[W], ov, (t[W-1:0] == '0), t[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rword();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      2:       r = 64'(1) << (W - 1);
      3:       r = ~(64'(1) << (W - 1));
      default: r = {$urandom, $urandom};
    endcase
    return r[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sub, input logic [W+2:0] e);
    int n;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.ci = ci;
    bus.sub = sub;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
    if (bus.in_ready) begin
      exp_q.push_back(e);
      acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_latency(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(cyc - acc_cyc), 64'd4);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      last_hand = cyc + 1;
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL unexpected_output: observed s=%0h expected no result", bus.s);
      end
      if (exp_q.size() > 0) begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        n_checks--;
        chk("result", 64'({bus.co, bus.ovf, bus.zero, bus.s}), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, sent, stall_left, first_acc, nc, hi;
    logic hold;
    logic [W-1:0] ra, rb;
    logic rci, rsub;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ci = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_s", 64'(bus.s), 64'd0);
    chk("rst_co", {63'd0, bus.co}, 64'd0);
    chk("rst_ovf", {63'd0, bus.ovf}, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd1);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed add/sub corner cases; first one also measures latency
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b1, 32'h0000_0000));
    wait_latency("latency_first");
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pk(1'b0, 1'b1, 1'b0, 32'h8000_0000));
    send(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 32'h0001_0001));
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, pk(1'b1, 1'b0, 1'b0, 32'h0000_0002));
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE));
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, pk(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF));
    send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, pk(1'b1, 1'b0, 1'b0, 32'h0000_0001));
    drain("directed_drain");

    // Stream of 8 ops with a 3-cycle output stall after the 2nd result
    base = n_out;
    sent = 0;
    stall_left = 3;
    first_acc = 0;
    nc = 0;
    while ((n_out - base) < 8 && nc < 60) begin
      if ((n_out - base) >= 2 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.in_valid = (sent < 8);
      bus.a = W'(sent + 1);
      bus.b = W'(sent + 1);
      bus.ci = 1'b0;
      bus.sub = 1'b0;
      @(negedge clk);
      chk("stream_in_ready", {63'd0, bus.in_ready}, {63'd0, bus.out_ready});
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, W'(2 * (sent + 1))));
        if (sent == 0) first_acc = cyc + 1;
        sent++;
      end
      @(posedge clk);
      #1;
      nc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 64'(n_out - base), 64'd8);
    chk("stream_total_cycles", 64'(last_hand - first_acc), 64'd15);
    chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with 3 ops in flight, inputs active during reset
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'(100 + i);
      bus.b = W'(7);
      bus.sub = 1'b0;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    bus.a = 32'h1111_1111;
    @(posedge clk);
    #1;
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("flush_zero", {63'd0, bus.zero}, 64'd1);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      hi += int'(bus.out_valid);
    end
    chk("no_stale_after_reset", 64'(hi), 64'd0);
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 32'h2345_6789));
    wait_latency("latency_after_reset");
    drain("reset_drain");

    // Random traffic with random stalls and bubbles
    sent = 0;
    nc = 0;
    hold = 1'b0;
    while (sent < 10000 && nc < 60000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        ra = rword();
        rb = rword();
        rci = 1'($urandom_range(0, 1));
        rsub = 1'($urandom_range(0, 1));
        bus.a = ra;
        bus.b = rb;
        bus.ci = rci;
        bus.sub = rsub;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
        sent++;
        hold = 1'b0;
      end else begin
        hold = bus.in_valid;
      end
      @(posedge clk);
      #1;
      nc++;
    end
    chk("random_sent", 64'(sent), 64'd10000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
